// File: rtl/tile_flusher_pkg.sv
// Shared constants, state encoding and FIFO entry layout for the tile flusher.
package tile_flusher_pkg;

    localparam int TILE_WIDTH  = 80;
    localparam int TILE_HEIGHT = 10;

    localparam logic [31:0] WIPE_PIXEL = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READING,
        ST_DRAINING,
        ST_DONE
    } flush_state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [10:0] x;
        logic [9:0]  y;
    } pixel_entry_t;

endpackage

// File: rtl/tile_flush_fifo.sv
// Synchronous output FIFO for the tile flusher: push/pop, occupancy count and flush.
module tile_flush_fifo
    import tile_flusher_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  pixel_entry_t     i_data,
    input  logic             i_pop,
    output pixel_entry_t     o_data,
    output logic [CNT_W-1:0] o_count
);

    pixel_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the occupancy count decides what is visible.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/tile_flusher.sv
// Drains a painted 80x10 tile from BRAM in raster order as coordinate-tagged pixels.
// Optional TILE_FLUSH_SKIP_EMPTY_EN: wipe-valued words are dropped instead of emitted.
module tile_flusher
    import tile_flusher_pkg::*;
#(
    parameter int BRAM_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        active,
    input  logic [10:0] x_offset,
    input  logic [9:0]  y_offset,
    output logic [9:0]  tile_bram_read_addr,
    input  logic [31:0] tile_bram_read_data,
    output logic        pixel_valid,
    input  logic        pixel_ready,
    output logic [31:0] pixel_data,
    output logic [10:0] pixel_x,
    output logic [9:0]  pixel_y,
    output logic        done
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    flush_state_t r_state;
    flush_state_t w_next_state;

    logic [10:0] r_x_off;
    logic [9:0]  r_y_off;
    logic [6:0]  r_x;
    logic [3:0]  r_y;
    logic [9:0]  r_addr;

    logic [BRAM_LATENCY-1:0] r_pipe_vld;
    logic [10:0]             r_pipe_x [BRAM_LATENCY];
    logic [9:0]              r_pipe_y [BRAM_LATENCY];

    logic [7:0]       w_inflight;
    logic [CNT_W-1:0] w_count;
    logic             w_credit;
    logic             w_issue;
    logic             w_last;
    logic             w_push;
    logic             w_pop;
    pixel_entry_t     w_push_entry;
    pixel_entry_t     w_head;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < BRAM_LATENCY; i++) w_inflight = w_inflight + 8'(r_pipe_vld[i]);
    end

    // Credit counts reads in flight so a full FIFO can never be overrun by returning data.
    assign w_credit = (8'(w_count) + w_inflight) < 8'(FIFO_DEPTH);
    assign w_issue  = (r_state == ST_READING) && active && w_credit;
    assign w_last   = (r_x == 7'(TILE_WIDTH - 1)) && (r_y == 4'(TILE_HEIGHT - 1));
    assign w_pop    = pixel_valid && pixel_ready;

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        done         = 1'b0;
        case (r_state)
            ST_IDLE:     if (active) w_next_state = ST_READING;
            ST_READING:  if (w_issue && w_last) w_next_state = ST_DRAINING;
            ST_DRAINING: if (w_inflight == '0 &&
                             (w_count == '0 || (w_count == CNT_W'(1) && w_pop)))
                             w_next_state = ST_DONE;
            ST_DONE:     done = 1'b1;
            default:     w_next_state = ST_IDLE;
        endcase
        if (!active) w_next_state = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x_off <= '0;
            r_y_off <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_addr  <= '0;
        end else if (!active) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
        end else if (r_state == ST_IDLE) begin
            r_x_off <= x_offset;
            r_y_off <= y_offset;
        end else if (w_issue && !w_last) begin
            r_addr <= r_addr + 1'b1;
            if (r_x == 7'(TILE_WIDTH - 1)) begin
                r_x <= '0;
                r_y <= r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !active) begin
            r_pipe_vld <= '0;
        end else begin
            r_pipe_vld[0] <= w_issue;
            for (int i = 1; i < BRAM_LATENCY; i++) r_pipe_vld[i] <= r_pipe_vld[i-1];
        end
    end

    // Screen coordinates travel with the read so they meet their data at the FIFO input.
    always_ff @(posedge clk) begin
        r_pipe_x[0] <= r_x_off + 11'(r_x);
        r_pipe_y[0] <= r_y_off + 10'(r_y);
        for (int i = 1; i < BRAM_LATENCY; i++) begin
            r_pipe_x[i] <= r_pipe_x[i-1];
            r_pipe_y[i] <= r_pipe_y[i-1];
        end
    end

    always_comb begin
        w_push_entry.data = tile_bram_read_data;
        w_push_entry.x    = r_pipe_x[BRAM_LATENCY-1];
        w_push_entry.y    = r_pipe_y[BRAM_LATENCY-1];
`ifdef TILE_FLUSH_SKIP_EMPTY_EN
        w_push = r_pipe_vld[BRAM_LATENCY-1] && (tile_bram_read_data != WIPE_PIXEL);
`else
        w_push = r_pipe_vld[BRAM_LATENCY-1];
`endif
    end

    tile_flush_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (!active),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count)
    );

    assign tile_bram_read_addr = r_addr;
    assign pixel_valid         = (w_count != '0);
    assign pixel_data          = w_head.data;
    assign pixel_x             = w_head.x;
    assign pixel_y             = w_head.y;

endmodule

// File: tb/tb_tile_flusher.sv
// Self-checking bench for tile_flusher: BRAM model, raster-order expectation queue, handshake monitor.
module tb_tile_flusher;

    localparam int W      = 80;
    localparam int H      = 10;
    localparam int NPIX   = W * H;
    localparam int LAT    = 2;
`ifdef TILE_FLUSH_SKIP_EMPTY_EN
    localparam int WIPED_XFERS = 0;
`else
    localparam int WIPED_XFERS = 800;
`endif

    typedef struct packed {
        logic [31:0] d;
        logic [10:0] x;
        logic [9:0]  y;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        active;
    logic [10:0] x_offset;
    logic [9:0]  y_offset;
    logic [9:0]  tile_bram_read_addr;
    logic [31:0] tile_bram_read_data;
    logic        pixel_valid;
    logic        pixel_ready;
    logic [31:0] pixel_data;
    logic [10:0] pixel_x;
    logic [9:0]  pixel_y;
    logic        done;

    logic [31:0] mem [NPIX];
    logic [31:0] bram_d1, bram_d2;

    exp_t exp_q[$];
    exp_t e;
    int   n_vec = 0;
    int   n_err = 0;
    int   xfer_cnt;
    logic mon_en;
    logic held;
    logic [31:0] hold_d, first_d, last_d;
    logic [10:0] hold_x, first_x, last_x;
    logic [9:0]  hold_y, first_y, last_y;

    tile_flusher #(.BRAM_LATENCY(LAT), .FIFO_DEPTH(4)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .active              (active),
        .x_offset            (x_offset),
        .y_offset            (y_offset),
        .tile_bram_read_addr (tile_bram_read_addr),
        .tile_bram_read_data (tile_bram_read_data),
        .pixel_valid         (pixel_valid),
        .pixel_ready         (pixel_ready),
        .pixel_data          (pixel_data),
        .pixel_x             (pixel_x),
        .pixel_y             (pixel_y),
        .done                (done)
    );

    always #5 clk = ~clk;

    // Two-cycle read-latency tile BRAM.
    always @(posedge clk) begin
        bram_d1 <= (int'(tile_bram_read_addr) < NPIX) ? mem[tile_bram_read_addr] : 32'h0;
        bram_d2 <= bram_d1;
    end
    assign tile_bram_read_data = bram_d2;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    // Handshake monitor: checks every transfer against the model and holds during stalls.
    always @(negedge clk) begin
        if (!mon_en) begin
            held = 1'b0;
        end else if (pixel_valid) begin
            if (held) begin
                check("hold_data", 64'(pixel_data), 64'(hold_d));
                check("hold_x", 64'(pixel_x), 64'(hold_x));
                check("hold_y", 64'(pixel_y), 64'(hold_y));
            end
            if (pixel_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL extra_pixel: got (%0d,%0d,%0h), want no transfer",
                             pixel_x, pixel_y, pixel_data);
                end else begin
                    e = exp_q.pop_front();
                    check("pix_data", 64'(pixel_data), 64'(e.d));
                    check("pix_x", 64'(pixel_x), 64'(e.x));
                    check("pix_y", 64'(pixel_y), 64'(e.y));
                    if (xfer_cnt == 0) begin
                        first_d = pixel_data; first_x = pixel_x; first_y = pixel_y;
                    end
                    last_d = pixel_data; last_x = pixel_x; last_y = pixel_y;
                    xfer_cnt++;
                end
                held = 1'b0;
            end else begin
                held   = 1'b1;
                hold_d = pixel_data;
                hold_x = pixel_x;
                hold_y = pixel_y;
            end
        end else begin
            if (held) check("valid_held", 64'(pixel_valid), 64'd1);
            held = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setup(input int xo, input int yo);
        x_offset = 11'(xo);
        y_offset = 10'(yo);
        xfer_cnt = 0;
        exp_q.delete();
        for (int a = 0; a < NPIX; a++) begin
`ifdef TILE_FLUSH_SKIP_EMPTY_EN
            if (mem[a] == 32'hFFFF_FFFF) continue;
`endif
            exp_q.push_back('{d: mem[a], x: 11'(xo + a % W), y: 10'(yo + a / W)});
        end
    endtask

    // pat 0: ready always high; pat 1: one cycle on, two off.
    task automatic run_flush(input string name, input int pat, input bit chk_first,
                             input bit chk_806, input int budget);
        int k = 0;
        int first_v = 9999;
        mon_en = 1'b1;
        active = 1'b1;
        while (!done && k < budget) begin
            pixel_ready = (pat == 1) ? (k % 3 == 0) : 1'b1;
            tick();
            k++;
            if (pixel_valid && first_v == 9999) first_v = k;
        end
        check({name, "_done_reached"}, 64'(done), 64'd1);
        check({name, "_all_consumed"}, 64'(exp_q.size()), 64'd0);
        if (chk_first) check({name, "_first_valid_latency"}, 64'(first_v <= 1 + LAT + 2), 64'd1);
        if (chk_806)   check({name, "_done_by_806"}, 64'(k <= 806), 64'd1);
    endtask

    task automatic go_idle();
        mon_en      = 1'b0;
        active      = 1'b0;
        pixel_ready = 1'b0;
        tick();
        check("idle_done", 64'(done), 64'd0);
        check("idle_valid", 64'(pixel_valid), 64'd0);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        int k;
        rst = 1'b1; active = 1'b0; pixel_ready = 1'b0;
        x_offset = '0; y_offset = '0; mon_en = 1'b0; held = 1'b0; xfer_cnt = 0;
        for (int a = 0; a < NPIX; a++) mem[a] = 32'(a);
        repeat (3) tick();
        check("reset_valid", 64'(pixel_valid), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_addr", 64'(tile_bram_read_addr), 64'd0);
        rst = 1'b0;
        tick();

        // Ramp tile, full throughput.
        setup(160, 20);
        run_flush("ramp", 0, 1'b1, 1'b1, 900);
        check("ramp_count", 64'(xfer_cnt), 64'd800);
        check("ramp_first_d", 64'(first_d), 64'd0);
        check("ramp_first_x", 64'(first_x), 64'd160);
        check("ramp_first_y", 64'(first_y), 64'd20);
        check("ramp_last_d", 64'(last_d), 64'd799);
        check("ramp_last_x", 64'(last_x), 64'd239);
        check("ramp_last_y", 64'(last_y), 64'd29);
        go_idle();

        // Toggling backpressure with coordinates that wrap modulo their widths.
        setup(2000, 1020);
        run_flush("toggle", 1, 1'b0, 1'b0, 3000);
        check("toggle_count", 64'(xfer_cnt), 64'd800);
        check("toggle_first_x", 64'(first_x), 64'd2000);
        check("toggle_last_x", 64'(last_x), 64'd31);
        check("toggle_last_y", 64'(last_y), 64'd5);
        go_idle();

        // Long stall at start: only FIFO_DEPTH reads may be issued.
        setup(160, 20);
        mon_en = 1'b1;
        active = 1'b1;
        pixel_ready = 1'b0;
        repeat (50) tick();
        check("stall_addr", 64'(tile_bram_read_addr), 64'd4);
        check("stall_valid", 64'(pixel_valid), 64'd1);
        check("stall_no_xfer", 64'(xfer_cnt), 64'd0);
        run_flush("stall", 0, 1'b0, 1'b0, 900);
        check("stall_count", 64'(xfer_cnt), 64'd800);
        go_idle();

        // Abort at pixel 300, then restart from address 0.
        setup(160, 20);
        mon_en = 1'b1;
        active = 1'b1;
        pixel_ready = 1'b1;
        k = 0;
        while (xfer_cnt < 300 && k < 1000) begin
            tick();
            k++;
        end
        check("abort_reached", 64'(xfer_cnt), 64'd300);
        mon_en = 1'b0;
        active = 1'b0;
        pixel_ready = 1'b0;
        tick();
        check("abort_valid", 64'(pixel_valid), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        setup(160, 20);
        run_flush("restart", 0, 1'b1, 1'b1, 900);
        check("restart_count", 64'(xfer_cnt), 64'd800);
        check("restart_first_d", 64'(first_d), 64'd0);
        go_idle();

        // Synchronous reset in the middle of READING.
        mon_en = 1'b0;
        active = 1'b1;
        pixel_ready = 1'b1;
        repeat (20) tick();
        rst = 1'b1;
        tick();
        check("midrst_valid", 64'(pixel_valid), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_addr", 64'(tile_bram_read_addr), 64'd0);
        rst = 1'b0;
        go_idle();

        // Fully wiped tile.
        for (int a = 0; a < NPIX; a++) mem[a] = 32'hFFFF_FFFF;
        setup(160, 20);
        run_flush("wiped", 0, 1'b0, 1'b1, 900);
        check("wiped_count", 64'(xfer_cnt), 64'(WIPED_XFERS));
        go_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
